// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: three-state issue/capture/write-back sequencer around a combinational ALU
module alu_issue_ctrl #(
  parameter logic [7:0] NOP_OP = 8'h16,
  parameter logic [7:0] CMP_OP = 8'h0A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [7:0]  op_in,
  input  logic [3:0]  rdest,
  input  logic [3:0]  rsrc,
  input  logic [7:0]  imm,
  input  logic        use_imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [7:0]  alu_opcode,
  input  logic [15:0] alu_c,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic        done,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [7:0]  op_q, op_d, lop_q, lop_d;
  logic [3:0]  rd_q, rd_d;
  logic [4:0]  f_q, f_d, psr_q, psr_d;
  logic        done_q, done_d;
  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];
  assign instr_ready = state_q == IDLE;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_opcode  = op_q;
  assign psr         = psr_q;
  assign done        = done_q;
  assign dbg_data    = regs_q[dbg_addr];
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    op_d    = op_q;
    lop_d   = lop_q;
    rd_d    = rd_q;
    f_d     = f_q;
    psr_d   = psr_q;
    done_d  = 1'b0;
    regs_d  = regs_q;
    case (state_q)
      IDLE: if (instr_valid) begin
        a_d     = regs_q[rdest];
        b_d     = use_imm ? {{8{imm[7]}}, imm} : regs_q[rsrc];
        op_d    = op_in;
        lop_d   = op_in;
        rd_d    = rdest;
        state_d = EXEC;
      end
      EXEC: begin
        c_d     = alu_c;
        f_d     = alu_flags;
        state_d = WB;
      end
      WB: begin
        if (lop_q != NOP_OP && lop_q != CMP_OP) regs_d[rd_q] = c_q;
        psr_d   = lop_q != NOP_OP ? f_q : psr_q;
        done_d  = 1'b1;
        op_d    = NOP_OP;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // reset outranks everything, including an in-flight write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      op_q    <= NOP_OP;
      lop_q   <= NOP_OP;
      rd_q    <= '0;
      f_q     <= '0;
      psr_q   <= '0;
      done_q  <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      op_q    <= op_d;
      lop_q   <= lop_d;
      rd_q    <= rd_d;
      f_q     <= f_d;
      psr_q   <= psr_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: ALU stub plus instruction-level reference model, checked every cycle
module tb_alu_issue_ctrl;
  localparam logic [7:0] ADD = 8'h00, SUB = 8'h01, CMP = 8'h0A, NOP = 8'h16;
  logic        clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, use_imm = 1'b0;
  logic [7:0]  op_in = '0, imm = '0;
  logic [3:0]  rdest = '0, rsrc = '0, dbg_addr = '0;
  logic        instr_ready, done;
  logic [15:0] alu_a, alu_b, alu_c, dbg_data;
  logic [7:0]  alu_opcode;
  logic [4:0]  alu_flags, psr, stub_flags = '0;
  int errors = 0, checks = 0, done_cnt = 0;
  bit armed = 0;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op_in(op_in), .rdest(rdest), .rsrc(rsrc), .imm(imm), .use_imm(use_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_c(alu_c),
    .alu_flags(alu_flags), .psr(psr), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(logic [15:0] a, logic [15:0] b, logic [7:0] op);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      CMP:     return 16'h0000;
      default: return 16'hDEAD;
    endcase
  endfunction

  assign alu_c     = ref_alu(alu_a, alu_b, alu_opcode);
  assign alu_flags = stub_flags;

  // instruction-level model: busy counts cycles left until retirement
  logic [15:0] m_regs [16];
  logic [15:0] m_a, m_b, p_res;
  logic [7:0]  m_op, p_op;
  logic [3:0]  p_rd;
  logic [4:0]  m_psr, p_fl;
  logic        m_done;
  int          busy;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] <= '0;
      m_psr <= '0; busy <= 0; m_done <= 1'b0; m_op <= NOP; m_a <= '0; m_b <= '0;
    end else begin
      m_done <= 1'b0;
      if (busy == 0) begin
        if (instr_valid) begin
          p_op <= op_in; p_rd <= rdest; m_op <= op_in;
          m_a <= m_regs[rdest];
          m_b <= use_imm ? 16'($signed(imm)) : m_regs[rsrc];
          busy <= 2;
        end
      end else if (busy == 2) begin
        p_res <= ref_alu(m_a, m_b, p_op);
        p_fl <= stub_flags;
        busy <= 1;
      end else begin
        if (p_op != NOP && p_op != CMP) m_regs[p_rd] <= p_res;
        if (p_op != NOP) m_psr <= p_fl;
        m_done <= 1'b1; m_op <= NOP; busy <= 0;
      end
    end
  end

  task automatic lit(string n, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (armed) begin
    lit("ready", 16'(instr_ready), 16'(busy == 0));
    lit("done", 16'(done), 16'(m_done));
    lit("psr", 16'(psr), 16'(m_psr));
    lit("alu_a", alu_a, m_a);
    lit("alu_b", alu_b, m_b);
    lit("alu_opcode", 16'(alu_opcode), 16'(m_op));
    lit("dbg_data", dbg_data, m_regs[dbg_addr]);
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      dbg_addr = dbg_addr + 4'd1;
    end
  endtask

  task automatic rd(logic [3:0] a, logic [15:0] exp, string n);
    dbg_addr = a; #1;
    lit(n, dbg_data, exp);
  endtask

  task automatic drive(logic [7:0] op, logic [3:0] rdd, logic [3:0] rs, logic [7:0] im, logic ui);
    op_in = op; rdest = rdd; rsrc = rs; imm = im; use_imm = ui;
  endtask

  task automatic issue(logic [7:0] op, logic [3:0] rdd, logic [3:0] rs, logic [7:0] im,
                       logic ui, logic [15:0] exp_b);
    int n = 0, d0;
    while (instr_ready !== 1'b1 && n < 10) begin tick(); n++; end
    if (n == 10) lit("ready_timeout", 16'(instr_ready), 16'd1);
    d0 = done_cnt;
    drive(op, rdd, rs, im, ui);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    lit("issue_alu_b", alu_b, exp_b);
    lit("issue_busy", 16'(instr_ready), 16'd0);
    tick(2);
    lit("issue_done_hi", 16'(done), 16'd1);
    tick();
    lit("issue_done_lo", 16'(done), 16'd0);
    lit("issue_one_pulse", 16'(done_cnt - d0), 16'd1);
  endtask

  initial begin
    logic [15:0] v;
    int d0;
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    int d0;
    tick(2);
    armed = 1;
    lit("rst_ready", 16'(instr_ready), 16'd1);
    lit("rst_done", 16'(done), 16'd0);
    lit("rst_psr", 16'(psr), 16'd0);
    lit("rst_opcode", 16'(alu_opcode), 16'h0016);
    for (int i = 0; i < 16; i++) begin dbg_addr = 4'(i); #0.5; lit("rst_reg", dbg_data, 16'd0); end
    tick();
    reset = 1'b0;
    tick();
    // ADD immediate and sign-extended immediate wrap
    stub_flags = 5'b00100;
    issue(ADD, 4'd1, 4'd0, 8'h05, 1'b1, 16'h0005);
    rd(4'd1, 16'h0005, "add_r1");
    lit("add_psr", 16'(psr), 16'h0004);
    tick();
    issue(ADD, 4'd1, 4'd0, 8'hFF, 1'b1, 16'hFFFF);
    rd(4'd1, 16'h0004, "add_wrap_r1");
    tick();
    stub_flags = 5'b01000;
    issue(ADD, 4'd2, 4'd0, 8'h07, 1'b1, 16'h0007);
    issue(SUB, 4'd5, 4'd0, 8'h02, 1'b1, 16'h0002);
    rd(4'd5, 16'hFFFE, "sub_r5");
    tick();
    // CMP updates only the PSR
    stub_flags = 5'b00011;
    issue(CMP, 4'd1, 4'd2, 8'h00, 1'b0, 16'h0007);
    rd(4'd1, 16'h0004, "cmp_r1_kept");
    lit("cmp_psr", 16'(psr), 16'h0003);
    tick();
    // NOP touches neither registers nor PSR
    stub_flags = 5'b11111;
    issue(NOP, 4'd1, 4'd2, 8'h00, 1'b0, 16'h0007);
    rd(4'd1, 16'h0004, "nop_r1_kept");
    lit("nop_psr", 16'(psr), 16'h0003);
    tick();
    // valid held for 9 cycles: accepts on cycles 0, 3, 6
    stub_flags = 5'b00001;
    d0 = done_cnt;
    instr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(ADD, 4'(4 + i), 4'd0, 8'(i + 1), 1'b1);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    tick(2);
    lit("burst_pulses", 16'(done_cnt - d0), 16'd3);
    rd(4'd4, 16'h0001, "burst_r4");
    rd(4'd5, 16'hFFFE, "burst_r5");
    rd(4'd7, 16'h0004, "burst_r7");
    tick();
    rd(4'd10, 16'h0007, "burst_r10");
    rd(4'd12, 16'h0000, "burst_r12");
    tick();
    // build R3 = 0x1234 through register-operand doubling
    stub_flags = 5'b00000;
    issue(ADD, 4'd3, 4'd0, 8'h12, 1'b1, 16'h0012);
    v = 16'h0012;
    for (int i = 0; i < 8; i++) begin
      issue(ADD, 4'd3, 4'd3, 8'h00, 1'b0, v);
      v = v << 1;
    end
    issue(ADD, 4'd3, 4'd0, 8'h34, 1'b1, 16'h0034);
    rd(4'd3, 16'h1234, "build_r3");
    tick();
    // reset at T1 aborts the instruction
    d0 = done_cnt;
    drive(ADD, 4'd3, 4'd0, 8'h01, 1'b1);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lit("abort_ready", 16'(instr_ready), 16'd1);
    tick(4);
    lit("abort_no_done", 16'(done_cnt - d0), 16'd0);
    rd(4'd3, 16'h0000, "abort_r3");
    rd(4'd1, 16'h0000, "abort_r1");
    tick();
    // reset coincident with valid in IDLE is not an accept
    drive(ADD, 4'd6, 4'd0, 8'h09, 1'b1);
    instr_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; reset = 1'b0;
    lit("rst_valid_ready", 16'(instr_ready), 16'd1);
    tick(3);
    rd(4'd6, 16'h0000, "rst_valid_r6");
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/write-back sequencer that drives the combinational `alu` block and consumes its results. It accepts one decoded instruction per valid/ready handshake and reads operands from an internal 16×16-bit register file. It presents A/B/Opcode to the ALU, captures C and Flags, then writes the result back to the destination register and the 5-bit processor status register (PSR). It sits between the instruction decoder and the ALU, on the opposite side of the ALU's A/B/Opcode → C/Flags interface.

## Interface
- `NOP_OP`, default 8'h16, opcode driven to the ALU when idle or in reset; no write-back, no PSR update.
- `CMP_OP`, default 8'h0A, compare opcode; PSR updated, no register write.
- `clk  in  1  sole clock, rising edge`
- `reset  in  1  synchronous, active-high; one clock, synchronous reset`
- `instr_valid  in  1  instruction fields valid`
- `instr_ready  out  1  block can accept; high only in IDLE`
- `op_in  in  8  opcode, forwarded unchanged to ALU`
- `rdest  in  4  destination register / operand A source`
- `rsrc  in  4  operand B source register`
- `imm  in  8  immediate, sign-extended to 16 bits`
- `use_imm  in  1  1: B = sext(imm); 0: B = R[rsrc]`
- `alu_a, alu_b  out  16  registered ALU operands`
- `alu_opcode  out  8  registered ALU opcode`
- `alu_c  in  16  ALU result`
- `alu_flags  in  5  ALU flags {Z,C,F,L,N} = [4:0]`
- `psr  out  5  registered status flags`
- `done  out  1  one-cycle pulse, instruction retired`
- `dbg_addr  in  4  debug read address`
- `dbg_data  out  16  combinational read of R[dbg_addr]`

## Operation
- States: IDLE, EXEC, WB. `instr_ready = (state == IDLE)`.
- IDLE with `instr_valid` high on an edge accepts the instruction:
  - `alu_a <= R[rdest]`.
  - `alu_b <= use_imm ? {{8{imm[7]}},imm} : R[rsrc]`.
  - `alu_opcode <= op_in`; latch `rdest` and `op_in`.
  - Next state EXEC.
- EXEC: the ALU output settles combinationally from the registered operands. On the edge, `c_q <= alu_c`, `f_q <= alu_flags`. Next state WB.
- WB, on the edge:
  - If the latched op is neither `NOP_OP` nor `CMP_OP`: `R[rdest_q] <= c_q`.
  - If the latched op is not `NOP_OP`: `psr <= f_q`.
  - `done <= 1`; `alu_opcode <= NOP_OP`; next state IDLE.
- `done` is deasserted on every other edge.
- Opcodes are never decoded for arithmetic; all arithmetic is in the ALU. Writes are 16-bit and wrap modulo 2^16 as the ALU returns them.
- R0 is an ordinary writable register.
- `instr_valid` is ignored outside IDLE. Fields need only be stable on the accepting edge.
- `dbg_data` reflects register writes starting the cycle after the WB edge.

## Timing
- Accept at edge T0 → EXEC during T0–T1 → capture at T1 → write/PSR/`done` at T2.
- `done` is high for the cycle T2–T3. `instr_ready` rises at T2; the next accept is at T3 at the earliest.
- Throughput is one instruction per 3 cycles.
- No hazards: an instruction accepted at T3 reads the register written at T2.
- Reset values:
  - state IDLE, `instr_ready` 1, `done` 0.
  - `alu_a` = `alu_b` = 0, `alu_opcode` = `NOP_OP`, `psr` = 0.
  - all R[0..15] = 0; `c_q`, `f_q` = 0.
- Reset during EXEC or WB takes priority over every other action: the instruction is aborted, no register or PSR write occurs, and `done` stays 0.
- Reset coincident with `instr_valid` in IDLE: the instruction is not accepted.

## Test plan
Bench uses a behavioural ALU stub: ADD/SUB mod 2^16, CMP returning C=0 and a chosen flag pattern.
- Reset held 2 cycles → `instr_ready`=1, `done`=0, `psr`=0, `alu_opcode`=8'h16, `dbg_data`=0 for all 16 addresses.
- ADD(8'h00), use_imm, rdest=1, imm=8'h05 accepted at T0:
  - `alu_b`=16'h0005 after T0; `done` pulses after T2; R1=16'h0005.
  - Then imm=8'hFF: `alu_b`=16'hFFFF and R1=16'h0004.
- CMP(8'h0A), rdest=1, rsrc=2, stub flags 5'b00011 → R1 unchanged, `psr`=5'b00011 after T2, `done` pulses once.
- NOP(8'h16) with stub flags forced 5'b11111 → no register changes, `psr` holds its prior value, `done` pulses.
- `instr_valid` held high for 9 cycles with fields changing each cycle → exactly 3 accepts at 3-cycle spacing, each using the fields present on its accepting edge.
- Reset asserted at T1 of ADD to R3 (R3 was 16'h1234 before) → R3=0 (reset-cleared, not ALU result), `done` never pulses, IDLE the cycle after reset deasserts.
